// File: rtl/mips_int_ctrl.sv
// -----------------------------------------------------------------------------
// mips_int_ctrl -- prioritised interrupt controller for a MIPS-style CPU.
//
// Collects N_CH interrupt request lines into a pending register (edge or level
// triggered per channel), filters them through an enable register, and raises
// a single registered request (o_int) with the winning channel number
// (o_vec_id). Channel 0 has the highest priority. The CPU acknowledges with
// i_int_ack on handler entry and signals completion with i_eoi on eret.
// Optional nesting lets a higher-priority channel preempt the one in service.
//
// Ports:
//   i_clk         clock, all state updates on the rising edge
//   i_reset       synchronous active-high reset
//   i_irq_src     raw interrupt request lines (synchronous to i_clk)
//   i_mask_wr     strobe loading i_mask_wdata into the enable register
//   i_mask_wdata  new enable value (1 = channel enabled)
//   i_int_ack     CPU acknowledge pulse on handler entry
//   i_eoi         end-of-interrupt pulse on eret
//   o_int         registered interrupt request to the CPU
//   o_vec_id      channel number of the current request
//   o_pending     pending register
//   o_in_service  in-service register
//   o_enable      enable register
// -----------------------------------------------------------------------------
module mips_int_ctrl #(
  parameter int              N_CH     = 8,
  parameter logic [N_CH-1:0] EDGE_SEL = {N_CH{1'b1}},
  parameter bit              NEST_EN  = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_CH-1:0]         i_irq_src,
  input  logic                    i_mask_wr,
  input  logic [N_CH-1:0]         i_mask_wdata,
  input  logic                    i_int_ack,
  input  logic                    i_eoi,
  output logic                    o_int,
  output logic [$clog2(N_CH)-1:0] o_vec_id,
  output logic [N_CH-1:0]         o_pending,
  output logic [N_CH-1:0]         o_in_service,
  output logic [N_CH-1:0]         o_enable
);

  localparam int              VW   = $clog2(N_CH);
  localparam logic [N_CH-1:0] ZERO = {N_CH{1'b0}};
  localparam logic [N_CH-1:0] ONE  = {{(N_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SERV = 2'd2
  } state_t;

  // Index of the lowest set bit (highest priority); zero when none is set.
  function automatic logic [VW-1:0] f_lowest_idx(input logic [N_CH-1:0] v);
    logic [VW-1:0] idx;
    idx = {VW{1'b0}};
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = VW'(i);
      end
    end
    return idx;
  endfunction

  state_t          r_state;
  logic            r_int;
  logic [VW-1:0]   r_vec;
  logic [N_CH-1:0] r_pending;
  logic [N_CH-1:0] r_in_service;
  logic [N_CH-1:0] r_enable;
  logic [N_CH-1:0] r_irq_q;

  state_t          w_state_nxt;
  logic            w_int_nxt;
  logic [VW-1:0]   w_vec_nxt;
  logic [N_CH-1:0] w_pend_nxt;
  logic [N_CH-1:0] w_is_nxt;
  logic [N_CH-1:0] w_ack_oh;

  // A mask write takes effect on this cycle's request decisions, so a newly
  // enabled pending channel is requested without waiting for the register.
  logic [N_CH-1:0] w_en_eff;
  logic [N_CH-1:0] w_pe;
  logic [N_CH-1:0] w_edge;
  logic            w_ack;
  logic            w_eoi;
  logic [N_CH-1:0] w_is_after;
  logic [N_CH-1:0] w_is_low;
  logic [N_CH-1:0] w_is_after_low;
  logic            w_nest_now;
  logic            w_nest_after;

  assign w_en_eff   = i_mask_wr ? i_mask_wdata : r_enable;
  assign w_pe       = r_pending & w_en_eff;
  assign w_edge     = i_irq_src & ~r_irq_q;
  // int_ack is only meaningful in REQ; when it is taken, a same-cycle eoi is dropped.
  assign w_ack      = (r_state == S_REQ) && i_int_ack;
  assign w_eoi      = i_eoi && !w_ack && (r_in_service != ZERO);
  // Clearing the lowest set bit retires the highest-priority handler.
  assign w_is_after = r_in_service & (r_in_service - ONE);
  // Isolated lowest set bit; (low - 1) masks every higher-priority channel.
  assign w_is_low       = r_in_service & (~r_in_service + ONE);
  assign w_is_after_low = w_is_after & (~w_is_after + ONE);
  assign w_nest_now     = |(w_pe & (w_is_low - ONE));
  assign w_nest_after   = |(w_pe & (w_is_after_low - ONE));

  // One-hot of the channel being acknowledged this cycle.
  always_comb begin
    w_ack_oh = ZERO;
    if (w_ack) begin
      w_ack_oh[r_vec] = 1'b1;
    end else begin
      w_ack_oh = ZERO;
    end
  end

  // In-service update: eoi and ack are mutually exclusive by construction.
  always_comb begin
    w_is_nxt = r_in_service;
    if (w_eoi) begin
      w_is_nxt = w_is_after;
    end else begin
      w_is_nxt = r_in_service | w_ack_oh;
    end
  end

  // Pending update: edge channels latch until acked (a new edge wins over the
  // ack clear); level channels follow irq_src only while not in service.
  always_comb begin
    w_pend_nxt = r_pending;
    for (int i = 0; i < N_CH; i++) begin
      if (EDGE_SEL[i]) begin
        if (w_edge[i]) begin
          w_pend_nxt[i] = 1'b1;
        end else if (w_ack_oh[i]) begin
          w_pend_nxt[i] = 1'b0;
        end else begin
          w_pend_nxt[i] = r_pending[i];
        end
      end else begin
        if (r_in_service[i] || w_ack_oh[i]) begin
          w_pend_nxt[i] = 1'b0;
        end else begin
          w_pend_nxt[i] = i_irq_src[i];
        end
      end
    end
  end

  // FSM next-state, vector latch and request output.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    case (r_state)
      S_IDLE: begin
        if (w_pe != ZERO) begin
          w_state_nxt = S_REQ;
          w_vec_nxt   = f_lowest_idx(w_pe);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (w_ack) begin
          w_state_nxt = S_SERV;
        end else if (!w_en_eff[r_vec]) begin
          // Latched channel masked away: withdraw, keep pending.
          w_state_nxt = (w_is_nxt != ZERO) ? S_SERV : S_IDLE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_SERV: begin
        if (w_eoi) begin
          if (w_is_after == ZERO) begin
            if (w_pe != ZERO) begin
              w_state_nxt = S_REQ;
              w_vec_nxt   = f_lowest_idx(w_pe);
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (NEST_EN && w_nest_after) begin
            w_state_nxt = S_REQ;
            w_vec_nxt   = f_lowest_idx(w_pe);
          end else begin
            w_state_nxt = S_SERV;
          end
        end else if (NEST_EN && w_nest_now) begin
          w_state_nxt = S_REQ;
          w_vec_nxt   = f_lowest_idx(w_pe);
        end else begin
          w_state_nxt = S_SERV;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_vec_nxt   = {VW{1'b0}};
      end
    endcase
    // INT rises one cycle after REQ entry and drops as soon as REQ is left.
    w_int_nxt = (r_state == S_REQ) && (w_state_nxt == S_REQ);
  end

  // State and register bank; reset overrides every other input.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_int        <= 1'b0;
      r_vec        <= {VW{1'b0}};
      r_pending    <= ZERO;
      r_in_service <= ZERO;
      r_enable     <= ZERO;
      r_irq_q      <= ZERO;
    end else begin
      r_state      <= w_state_nxt;
      r_int        <= w_int_nxt;
      r_vec        <= w_vec_nxt;
      r_pending    <= w_pend_nxt;
      r_in_service <= w_is_nxt;
      r_enable     <= w_en_eff;
      r_irq_q      <= i_irq_src;
    end
  end

  assign o_int        = r_int;
  assign o_vec_id     = r_vec;
  assign o_pending    = r_pending;
  assign o_in_service = r_in_service;
  assign o_enable     = r_enable;

endmodule

// File: tb/tb_mips_int_ctrl.sv
// Testbench for mips_int_ctrl. Two instances share one stimulus stream:
// dut0 uses defaults (all edge, no nesting), dut1 has channel 3 level-triggered
// and nesting enabled. A reference model predicts every register each cycle.
module tb_mips_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_src;
  logic       mask_wr;
  logic [7:0] mask_wdata;
  logic       int_ack;
  logic       eoi;

  logic       int0, int1;
  logic [2:0] vec0, vec1;
  logic [7:0] pend0, pend1, isv0, isv1, en0, en1;

  always #5 clk = ~clk;

  mips_int_ctrl #(.N_CH(8), .EDGE_SEL(8'hFF), .NEST_EN(1'b0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_irq_src(irq_src), .i_mask_wr(mask_wr),
    .i_mask_wdata(mask_wdata), .i_int_ack(int_ack), .i_eoi(eoi),
    .o_int(int0), .o_vec_id(vec0), .o_pending(pend0), .o_in_service(isv0),
    .o_enable(en0)
  );

  mips_int_ctrl #(.N_CH(8), .EDGE_SEL(8'hF7), .NEST_EN(1'b1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_irq_src(irq_src), .i_mask_wr(mask_wr),
    .i_mask_wdata(mask_wdata), .i_int_ack(int_ack), .i_eoi(eoi),
    .o_int(int1), .o_vec_id(vec1), .o_pending(pend1), .o_in_service(isv1),
    .o_enable(en1)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endfunction

  // ---------------- reference model (one slot per instance) ----------------
  // state codes: 0 idle, 1 requesting, 2 servicing
  int       m_st[2];
  int       m_vec[2];
  bit       m_int[2];
  bit [7:0] m_pend[2], m_isv[2], m_en[2], m_irq_q[2];

  function automatic int lowest(bit [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int d);
    bit [7:0] es, en_eff, pe, nis, np;
    bit       nest, ack_ok, eoi_ok, rise;
    int       hp, low_is, low_after, nst, nvec;
    nest = (d == 1);
    es   = (d == 1) ? 8'hF7 : 8'hFF;
    if (reset) begin
      m_st[d] = 0; m_vec[d] = 0; m_int[d] = 1'b0;
      m_pend[d] = 8'h00; m_isv[d] = 8'h00; m_en[d] = 8'h00; m_irq_q[d] = 8'h00;
      return;
    end
    en_eff = mask_wr ? mask_wdata : m_en[d];
    pe     = m_pend[d] & en_eff;
    hp     = lowest(pe);
    low_is = lowest(m_isv[d]);
    ack_ok = (m_st[d] == 1) && int_ack;
    eoi_ok = eoi && !ack_ok && (low_is >= 0);
    nis = m_isv[d];
    if (eoi_ok) nis[low_is] = 1'b0;
    if (ack_ok) nis[m_vec[d]] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rise = irq_src[i] && !m_irq_q[d][i];
      if (es[i]) begin
        if (rise) np[i] = 1'b1;
        else if (ack_ok && i == m_vec[d]) np[i] = 1'b0;
        else np[i] = m_pend[d][i];
      end else begin
        np[i] = (m_isv[d][i] || (ack_ok && i == m_vec[d])) ? 1'b0 : irq_src[i];
      end
    end
    nst = m_st[d];
    nvec = m_vec[d];
    if (m_st[d] == 0) begin
      if (hp >= 0) begin nst = 1; nvec = hp; end
    end else if (m_st[d] == 1) begin
      if (ack_ok) nst = 2;
      else if (!en_eff[m_vec[d]]) nst = (nis != 8'h00) ? 2 : 0;
    end else begin
      if (eoi_ok) begin
        low_after = lowest(nis);
        if (low_after < 0) begin
          if (hp >= 0) begin nst = 1; nvec = hp; end
          else nst = 0;
        end else if (nest && hp >= 0 && hp < low_after) begin
          nst = 1; nvec = hp;
        end
      end else if (nest && hp >= 0 && hp < low_is) begin
        nst = 1; nvec = hp;
      end
    end
    m_int[d]   = (m_st[d] == 1) && (nst == 1);
    m_st[d]    = nst;
    m_vec[d]   = nvec;
    m_pend[d]  = np;
    m_isv[d]   = nis;
    m_en[d]    = en_eff;
    m_irq_q[d] = irq_src;
  endtask

  // ---------------- scoreboard ----------------
  logic [27:0] q0[$];
  logic [27:0] q1[$];
  logic [27:0] e0, e1;

  function automatic logic [27:0] pack_exp(int d);
    return {m_int[d], 3'(m_vec[d]), m_pend[d], m_isv[d], m_en[d]};
  endfunction

  // Monitor: registered outputs are compared on the falling edge.
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      chk("d0 INT",  32'(int0),  32'(e0[27]));
      chk("d0 vec",  32'(vec0),  32'(e0[26:24]));
      chk("d0 pend", 32'(pend0), 32'(e0[23:16]));
      chk("d0 isv",  32'(isv0),  32'(e0[15:8]));
      chk("d0 en",   32'(en0),   32'(e0[7:0]));
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      chk("d1 INT",  32'(int1),  32'(e1[27]));
      chk("d1 vec",  32'(vec1),  32'(e1[26:24]));
      chk("d1 pend", 32'(pend1), 32'(e1[23:16]));
      chk("d1 isv",  32'(isv1),  32'(e1[15:8]));
      chk("d1 en",   32'(en1),   32'(e1[7:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    q0.push_back(pack_exp(0));
    q1.push_back(pack_exp(1));
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    reset = 1'b0; irq_src = 8'h00; mask_wr = 1'b0; mask_wdata = 8'h00;
    int_ack = 1'b0; eoi = 1'b0;
  endtask

  task automatic ack_eoi();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, " d0"}, {int0, vec0, pend0, isv0, en0}, 32'h0);
    chk({nm, " d1"}, {int1, vec1, pend1, isv1, en1}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset = 1'b1;
    ticks(3);
    chk_zero("reset state");
    reset = 1'b0;

    // basic edge request on channel 5
    mask_wr = 1'b1; mask_wdata = 8'hFF; tick(); mask_wr = 1'b0;
    irq_src[5] = 1'b1; tick(); irq_src = 8'h00;
    chk("c5 pend t+1", 32'(pend0), 32'h20);
    ticks(2);
    chk("c5 INT t+3", 32'(int0), 32'h1);
    chk("c5 vec", 32'(vec0), 32'h5);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("c5 isv ack", 32'(isv0), 32'h20);
    chk("c5 pend ack", 32'(pend0), 32'h00);
    chk("c5 INT ack", 32'(int0), 32'h0);
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    chk("c5 isv eoi", 32'(isv0), 32'h00);

    // simultaneous channels 2 and 6
    irq_src = 8'h44; tick(); irq_src = 8'h00; ticks(2);
    chk("prio vec2", 32'(vec0), 32'h2);
    chk("prio INT", 32'(int0), 32'h1);
    ack_eoi(); tick();
    chk("prio vec6", 32'(vec0), 32'h6);
    chk("prio INT2", 32'(int0), 32'h1);
    ack_eoi(); tick();

    // disabled channel latches pending without requesting
    mask_wr = 1'b1; mask_wdata = 8'h00; tick(); mask_wr = 1'b0;
    irq_src[1] = 1'b1; tick(); irq_src = 8'h00; ticks(2);
    chk("mask pend", 32'(pend0), 32'h02);
    chk("mask INT0", 32'(int0), 32'h0);
    mask_wr = 1'b1; mask_wdata = 8'h02; tick(); mask_wr = 1'b0; tick();
    chk("unmask INT", 32'(int0), 32'h1);
    chk("unmask vec", 32'(vec0), 32'h1);
    ack_eoi();
    mask_wr = 1'b1; mask_wdata = 8'hFF; tick(); mask_wr = 1'b0;

    // masking the latched channel while requesting withdraws INT
    irq_src[2] = 1'b1; tick(); irq_src = 8'h00; ticks(2);
    chk("withdraw INT1", 32'(int0), 32'h1);
    mask_wr = 1'b1; mask_wdata = 8'hFB; tick(); mask_wr = 1'b0;
    chk("withdraw INT0", 32'(int0), 32'h0);
    chk("withdraw pend", 32'(pend0), 32'h04);
    mask_wr = 1'b1; mask_wdata = 8'hFF; tick(); mask_wr = 1'b0;
    ticks(2); ack_eoi(); tick();

    // nesting on dut1: channel 1 preempts channel 4
    irq_src[4] = 1'b1; tick(); irq_src = 8'h00; ticks(2);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("nest isv10", 32'(isv1), 32'h10);
    irq_src[1] = 1'b1; tick(); irq_src = 8'h00; ticks(2);
    chk("nest INT", 32'(int1), 32'h1);
    chk("nest vec", 32'(vec1), 32'h1);
    chk("nonest INT", 32'(int0), 32'h0);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("nest isv12", 32'(isv1), 32'h12);
    eoi = 1'b1; tick();
    chk("nest eoi1", 32'(isv1), 32'h10);
    tick(); eoi = 1'b0;
    chk("nest eoi2", 32'(isv1), 32'h00);
    tick();
    chk("nest idle INT", 32'(int1), 32'h0);
    ack_eoi(); tick();

    // level channel 3 on dut1 re-requests while held high
    irq_src[3] = 1'b1; ticks(3);
    chk("level INT1", 32'(int1), 32'h1);
    chk("level vec1", 32'(vec1), 32'h3);
    ack_eoi(); ticks(3);
    chk("level INT2", 32'(int1), 32'h1);
    chk("level vec2", 32'(vec1), 32'h3);
    irq_src = 8'h00; ack_eoi(); ticks(2);

    // reset mid-handshake
    irq_src[0] = 1'b1; tick(); irq_src = 8'h00; ticks(2);
    chk("rst pre INT", 32'(int0), 32'h1);
    reset = 1'b1; int_ack = 1'b1; irq_src = 8'h81; tick();
    reset = 1'b0; int_ack = 1'b0; irq_src = 8'h00;
    chk_zero("rst mid");

    // randomized traffic against the model
    for (int c = 0; c < 700; c++) begin
      irq_src    = 8'($urandom & $urandom);
      mask_wr    = ($urandom_range(0, 15) == 0);
      mask_wdata = 8'($urandom | $urandom);
      int_ack    = ($urandom_range(0, 3) == 0);
      eoi        = ($urandom_range(0, 4) == 0);
      reset      = ($urandom_range(0, 249) == 0);
      tick();
    end
    clr();
    ticks(2);
    #1;
    chk("sb drained d0", 32'(q0.size()), 32'h0);
    chk("sb drained d1", 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_int_ctrl.md
MIPS_INT_CTRL -- requirements
Module: mips_int_ctrl

Interface
REQ-001 Parameter N_CH, default 8, SHALL set the number of interrupt channels (2..32); channel 0 is highest priority.
REQ-002 Parameter EDGE_SEL, N_CH bits, default all ones, SHALL select the trigger per channel: 1 = rising edge, 0 = level-high.
REQ-003 Parameter NEST_EN, default 0, SHALL allow a higher-priority channel to preempt an in-service one when set to 1.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 irq_src  in  N_CH  SHALL carry raw interrupt request lines, synchronous to clk.
REQ-007 mask_wr  in  1  SHALL be the strobe that loads mask_wdata into the enable register.
REQ-008 mask_wdata  in  N_CH  SHALL be the new enable value; a 1 enables the channel.
REQ-009 int_ack  in  1  SHALL be the CPU acknowledge pulse on handler entry.
REQ-010 eoi  in  1  SHALL be the end-of-interrupt pulse, issued by the CPU on eret.
REQ-011 INT  out  1  SHALL be the registered interrupt request to the CPU.
REQ-012 vec_id  out  clog2(N_CH)  SHALL give the channel number of the current request.
REQ-013 pending  out  N_CH  SHALL expose the pending register.
REQ-014 in_service  out  N_CH  SHALL expose the in-service register.
REQ-015 enable  out  N_CH  SHALL expose the enable register.

Function
REQ-016 FSM SHALL have states IDLE, REQ and SERV.
  - IDLE->REQ when any bit of (pending & enable) is set.
  - REQ->SERV on int_ack.
  - SERV->IDLE on eoi when the in-service register becomes zero.
  - SERV->REQ under nesting, as in REQ-022.
REQ-017 Edge channel pending bit SHALL set the cycle after irq_src goes 0->1, detected against a registered copy of irq_src; it SHALL stay set until that channel is acknowledged.
REQ-018 Level channel pending bit SHALL equal irq_src, registered one cycle, while that channel is not in service.
REQ-019 Pending SHALL latch regardless of enable; disabled channels SHALL NOT cause REQ.
REQ-020 On REQ entry, vec_id SHALL latch the lowest-index bit of (pending & enable). INT SHALL assert on the following cycle, and vec_id SHALL stay frozen until int_ack.
REQ-021 On int_ack in REQ:
  - in_service[vec_id] SHALL set and pending[vec_id] SHALL clear in the same edge.
  - INT SHALL deassert on the next cycle.
  - If a new edge arrives on the same channel in that cycle, the set SHALL win and pending stays 1.
REQ-022 With NEST_EN=1, in SERV, when any enabled pending channel has an index lower than the lowest set in_service bit, the FSM SHALL go to REQ. With NEST_EN=0 it SHALL remain in SERV until eoi.
REQ-023 eoi SHALL clear the lowest-index set in_service bit. If enabled pending bits remain, the FSM SHALL go to REQ; otherwise it SHALL go to IDLE.
REQ-024 eoi with in_service zero, and int_ack outside REQ, SHALL be ignored.
REQ-025 When int_ack and eoi arrive in the same cycle, int_ack SHALL be processed and eoi ignored.
REQ-026 A mask_wr that disables the latched channel while in REQ SHALL drop INT the next cycle and return the FSM to IDLE (or to SERV if in_service is nonzero); pending SHALL be kept.
REQ-027 Worst-case latency from an irq_src edge to INT high SHALL be 3 cycles from IDLE.

Reset
REQ-028 Reset SHALL force state IDLE, INT=0, vec_id=0, pending=0, in_service=0, enable=0, and the registered irq_src copy=0.
REQ-029 Reset SHALL take priority over every other input in the same cycle, including mid-handshake.
REQ-030 The first cycle after reset SHALL NOT detect an edge on lines already high unless they were low in the registered copy.

Verification (N_CH=8, EDGE_SEL=8'hFF, NEST_EN=0 unless stated)
REQ-031 enable=FF; pulse irq_src[5] at cycle t -> pending=0x20 at t+1, INT=1 with vec_id=5 by t+3; int_ack -> in_service=0x20, pending=0, INT=0.
REQ-032 irq_src[6] and irq_src[2] rise together -> vec_id=2; after ack and eoi, second request has vec_id=6.
REQ-033 enable=0; pulse irq_src[1] -> pending=0x02, INT stays 0; write enable=0x02 -> INT within 2 cycles, vec_id=1.
REQ-034 NEST_EN=1; ch4 in service; pulse ch1 -> INT, vec_id=1; ack -> in_service=0x12; eoi -> 0x10; eoi -> 0x00, IDLE.
REQ-035 EDGE_SEL bit 3=0; hold irq_src[3] high through ack and eoi -> second request for channel 3 issued.
REQ-036 Assert reset in REQ with INT=1 -> next cycle INT=0, all registers zero.
